// File: rtl/lis_data_mem_pkg.sv
// Shared load-store definitions: opcode encodings, wait-state limit and
// access-legality helpers used by the data-memory responder.
package lis_data_mem_pkg;

   localparam int unsigned LIS_OP_W        = 3;
   localparam int unsigned WAIT_STATES_MAX = 15;
   localparam int unsigned WAIT_CNT_W      = 4;

   localparam logic [LIS_OP_W-1:0] LIS_LB  = 3'd0;
   localparam logic [LIS_OP_W-1:0] LIS_LH  = 3'd1;
   localparam logic [LIS_OP_W-1:0] LIS_LW  = 3'd2;
   localparam logic [LIS_OP_W-1:0] LIS_LBU = 3'd3;
   localparam logic [LIS_OP_W-1:0] LIS_LHU = 3'd4;
   localparam logic [LIS_OP_W-1:0] LIS_SB  = 3'd5;
   localparam logic [LIS_OP_W-1:0] LIS_SH  = 3'd6;
   localparam logic [LIS_OP_W-1:0] LIS_SW  = 3'd7;

   function automatic logic is_store(input logic [LIS_OP_W-1:0] op);
      return (op == LIS_SB) || (op == LIS_SH) || (op == LIS_SW);
   endfunction

   function automatic logic is_half(input logic [LIS_OP_W-1:0] op);
      return (op == LIS_LH) || (op == LIS_LHU) || (op == LIS_SH);
   endfunction

   function automatic logic is_word(input logic [LIS_OP_W-1:0] op);
      return (op == LIS_LW) || (op == LIS_SW);
   endfunction

   // Misaligned access or direction that disagrees with the opcode class
   function automatic logic op_err(input logic [LIS_OP_W-1:0] op,
                                   input logic                we,
                                   input logic [1:0]          off);
      return (is_half(op) & off[0]) | (is_word(op) & (off != 2'b00)) |
             (we != is_store(op));
   endfunction

endpackage

// File: rtl/lis_data_mem_ram.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port (1-cycle latency). Contents are not reset.
// Ports: clk; we/be/wdata write a word lane-wise; re/addr launch a read,
// rdata holds the last word read.
module lis_data_mem_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic                      re,
   input  logic [DATA_WIDTH/8-1:0]   be,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH-1:0]     rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned BE_W  = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Lane-masked write and registered read
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/lis_data_mem.sv
// Data-memory responder for the load-store path. Accepts one request at a
// time (req/gnt/rvalid), validates alignment and direction, steers store
// bytes into lanes and right-aligns load data.
// Ports: clk, rst_n; req_i/we_i/lis_op_i/addr_i/wdata_i request fields;
// gnt_o combinational accept; rvalid_o/rdata_o/err_o response; busy_o.
module lis_data_mem
   import lis_data_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MEM_ADDR_WIDTH = 10,
   parameter int unsigned LIS_OP_WIDTH   = LIS_OP_W,
   parameter int unsigned WAIT_STATES    = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [LIS_OP_WIDTH-1:0]   lis_op_i,
   input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      err_o,
   output logic                      busy_o
);

   localparam int unsigned RAM_AW = MEM_ADDR_WIDTH - 2;
   localparam int unsigned BE_W   = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [WAIT_CNT_W-1:0]     cnt_q, cnt_d;
   logic [LIS_OP_WIDTH-1:0]   op_q;
   logic                      we_q;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic                      resp_load_q, resp_load_d;
   logic [1:0]                resp_off_q, resp_off_d;
   logic                      rvalid_d, err_d, busy_d;
   logic                      req_err;
   logic                      ram_we, ram_re;
   logic [BE_W-1:0]           ram_be;
   logic [DATA_WIDTH-1:0]     ram_wdata, ram_rdata;

   assign gnt_o   = req_i & (state_q == S_IDLE);
   assign req_err = op_err(LIS_OP_W'(lis_op_i), we_i, addr_i[1:0]);

   // Next state, wait counter and registered response values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_o;
      resp_load_d = resp_load_q;
      resp_off_d  = resp_off_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_o) begin
               if (req_err)              state_d = S_RESP;
               else if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end
               else                      state_d = S_ACCESS;
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_CNT_W'(WAIT_STATES - 1)) state_d = S_ACCESS;
            else                                       cnt_d   = cnt_q + WAIT_CNT_W'(1);
         end
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      rvalid_d = (state_d == S_RESP);
      busy_d   = (state_d != S_IDLE);
      // RESP is entered from IDLE only on a rejected request
      if (state_d == S_RESP) begin
         err_d       = (state_q == S_IDLE);
         resp_load_d = (state_q == S_ACCESS) & ~we_q;
         resp_off_d  = addr_q[1:0];
      end
   end

   // State, request latch and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rvalid_o    <= 1'b0;
         err_o       <= 1'b0;
         busy_o      <= 1'b0;
         resp_load_q <= 1'b0;
         resp_off_q  <= 2'b00;
      end
      else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rvalid_o    <= rvalid_d;
         err_o       <= err_d;
         busy_o      <= busy_d;
         resp_load_q <= resp_load_d;
         resp_off_q  <= resp_off_d;
         if (gnt_o) begin
            op_q    <= lis_op_i;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
         end
      end
   end

   // Store lane steering; the RAM commits on the edge that ends ACCESS
   always_comb begin
      ram_be = '1;
      if (op_q == LIS_OP_WIDTH'(LIS_SB))      ram_be = BE_W'(4'b0001) << addr_q[1:0];
      else if (op_q == LIS_OP_WIDTH'(LIS_SH)) ram_be = BE_W'(4'b0011) << addr_q[1:0];
   end

   assign ram_wdata = wdata_q << {addr_q[1:0], 3'b000};
   assign ram_we    = (state_q == S_ACCESS) & we_q;
   assign ram_re    = (state_q == S_ACCESS) & ~we_q;

   // RAM word and offset are both held until the next response, so the
   // right-aligned result is stable for the whole inter-response interval
   assign rdata_o = resp_load_q ? (ram_rdata >> {resp_off_q, 3'b000}) : '0;

   lis_data_mem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .be    (ram_be),
      .addr  (addr_q[MEM_ADDR_WIDTH-1:2]),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_lis_data_mem.sv
// Bench for lis_data_mem: two instances (0 and 3 wait states) driven with
// directed and random requests, checked against a byte-array memory model.
module tb_lis_data_mem;
   import lis_data_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req [2];
   logic        we [2];
   logic [2:0]  op [2];
   logic [9:0]  addr [2];
   logic [31:0] wdata [2];
   logic        gnt [2];
   logic        rvalid [2];
   logic        err [2];
   logic        busy [2];
   logic [31:0] rdata [2];

   int checks = 0;
   int errors = 0;
   logic [7:0] mm [2][256];

   always #5 clk = ~clk;

   lis_data_mem #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_i(req[0]), .we_i(we[0]), .lis_op_i(op[0]),
      .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0]), .busy_o(busy[0]));

   lis_data_mem #(.WAIT_STATES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_i(req[1]), .we_i(we[1]), .lis_op_i(op[1]),
      .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1]), .busy_o(busy[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int op_size(input logic [2:0] o);
      if (o == LIS_LB || o == LIS_LBU || o == LIS_SB) return 1;
      if (o == LIS_LH || o == LIS_LHU || o == LIS_SH) return 2;
      return 4;
   endfunction

   function automatic bit op_store(input logic [2:0] o);
      return (o == LIS_SB) || (o == LIS_SH) || (o == LIS_SW);
   endfunction

   function automatic logic [31:0] model_word(input int d, input int base);
      return {mm[d][base+3], mm[d][base+2], mm[d][base+1], mm[d][base]};
   endfunction

   // One full request/response; expectations come from the byte model
   task automatic xact(input int d, input bit w, input logic [2:0] o, input logic [9:0] a,
                       input logic [31:0] wd, input string tag, output logic [31:0] rd);
      int ai, k, lat_exp, lat_got;
      bit e_exp;
      logic [31:0] d_exp;
      ai      = int'(a);
      e_exp   = ((ai % op_size(o)) != 0) || (w != op_store(o));
      lat_exp = e_exp ? 1 : 2 + ((d == 0) ? 0 : 3);
      d_exp   = (e_exp || w) ? 32'h0 : (model_word(d, ai - ai % 4) >> (8 * (ai % 4)));
      rd      = 'x;
      @(negedge clk);
      req[d] = 1'b1; we[d] = w; op[d] = o; addr[d] = a; wdata[d] = wd;
      k = 0;
      while (!gnt[d] && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!gnt[d]) begin
         chk($sformatf("d%0d_%s_gnt", d, tag), 32'(gnt[d]), 32'd1);
         req[d] = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req[d] = 1'b0;
      lat_got = 0;
      for (k = 1; k <= lat_exp + 4 && lat_got == 0; k++) begin
         @(negedge clk);
         if (rvalid[d]) begin
            lat_got = k;
            rd = rdata[d];
            chk($sformatf("d%0d_%s_err", d, tag), 32'(err[d]), 32'(e_exp));
            chk($sformatf("d%0d_%s_data", d, tag), rdata[d], d_exp);
         end
      end
      chk($sformatf("d%0d_%s_lat", d, tag), 32'(lat_got), 32'(lat_exp));
      if (lat_got != 0) begin
         @(negedge clk);
         chk($sformatf("d%0d_%s_rv1", d, tag), 32'(rvalid[d]), 32'd0);
      end
      if (!e_exp && w)
         for (int i = 0; i < op_size(o); i++) mm[d][ai+i] = wd[8*i +: 8];
   endtask

   initial begin
      logic [31:0] rd;
      bit rv_seen;
      int kr;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; op[d] = '0; addr[d] = '0; wdata[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_rst_rvalid", d), 32'(rvalid[d]), 32'd0);
         chk($sformatf("d%0d_rst_rdata", d), rdata[d], 32'd0);
         chk($sformatf("d%0d_rst_err", d), 32'(err[d]), 32'd0);
         chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
      end
      rst_n = 1'b1;

      // Give every word in the test window a known value
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 256; a += 4)
            xact(d, 1'b1, LIS_SW, 10'(a), $urandom, "init", rd);

      // Directed lane and error cases on both instances
      for (int d = 0; d < 2; d++) begin
         xact(d, 1'b1, LIS_SW, 10'h010, 32'hDEADBEEF, "sw", rd);
         chk($sformatf("d%0d_sw_rd0", d), rd, 32'h0);
         xact(d, 1'b0, LIS_LW, 10'h010, 32'h0, "lw1", rd);
         chk($sformatf("d%0d_lw1_c", d), rd, 32'hDEADBEEF);
         xact(d, 1'b1, LIS_SB, 10'h013, 32'h000000A5, "sb", rd);
         xact(d, 1'b0, LIS_LW, 10'h010, 32'h0, "lw2", rd);
         chk($sformatf("d%0d_lw2_c", d), rd, 32'hA5ADBEEF);
         xact(d, 1'b0, LIS_LBU, 10'h013, 32'h0, "lbu", rd);
         chk($sformatf("d%0d_lbu_c", d), rd, 32'h000000A5);
         xact(d, 1'b1, LIS_SH, 10'h012, 32'h00001234, "sh", rd);
         xact(d, 1'b0, LIS_LW, 10'h010, 32'h0, "lw3", rd);
         chk($sformatf("d%0d_lw3_c", d), rd, 32'h1234BEEF);
         xact(d, 1'b0, LIS_LH, 10'h012, 32'h0, "lh", rd);
         chk($sformatf("d%0d_lh_c", d), rd, 32'h00001234);
         xact(d, 1'b0, LIS_LW, 10'h011, 32'h0, "e_lw", rd);
         xact(d, 1'b1, LIS_SH, 10'h013, 32'hFFFFFFFF, "e_sh", rd);
         xact(d, 1'b1, LIS_LB, 10'h010, 32'hFFFFFFFF, "e_lbwe", rd);
         xact(d, 1'b0, LIS_LW, 10'h010, 32'h0, "lw4", rd);
         chk($sformatf("d%0d_lw4_c", d), rd, 32'h1234BEEF);
      end

      // Three wait states: busy window and a request held across it
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b1; op[1] = LIS_SW; addr[1] = 10'h020; wdata[1] = 32'hCAFEF00D;
      #1 chk("ws_gnt_t", 32'(gnt[1]), 32'd1);
      @(posedge clk);
      #1 we[1] = 1'b0; op[1] = LIS_LW;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("ws_busy_%0d", k), 32'(busy[1]), 32'd1);
         chk($sformatf("ws_gnt_%0d", k), 32'(gnt[1]), 32'd0);
         chk($sformatf("ws_rv_%0d", k), 32'(rvalid[1]), 32'(k == 5));
         if (k == 5) begin
            chk("ws_st_rdata", rdata[1], 32'h0);
            chk("ws_st_err", 32'(err[1]), 32'd0);
         end
      end
      for (int i = 0; i < 4; i++) mm[1][32+i] = 8'(32'hCAFEF00D >> (8 * i));
      @(negedge clk);
      chk("ws_gnt_idle", 32'(gnt[1]), 32'd1);
      chk("ws_busy_idle", 32'(busy[1]), 32'd0);
      @(posedge clk);
      #1 req[1] = 1'b0;
      repeat (4) @(negedge clk);
      @(negedge clk);
      chk("ws_ld_rv", 32'(rvalid[1]), 32'd1);
      chk("ws_ld_data", rdata[1], 32'hCAFEF00D);
      @(negedge clk);
      chk("ws_ld_rv1", 32'(rvalid[1]), 32'd0);

      // Reset during ACCESS discards the pending store
      for (int d = 0; d < 2; d++) begin
         kr = (d == 0) ? 1 : 4;
         @(negedge clk);
         req[d] = 1'b1; we[d] = 1'b1; op[d] = LIS_SW; addr[d] = 10'h010; wdata[d] = 32'hFFFFFFFF;
         @(posedge clk);
         #1 req[d] = 1'b0;
         repeat (kr) @(negedge clk);
         rst_n = 1'b0;
         #1;
         chk($sformatf("d%0d_mr_rvalid", d), 32'(rvalid[d]), 32'd0);
         chk($sformatf("d%0d_mr_rdata", d), rdata[d], 32'd0);
         chk($sformatf("d%0d_mr_err", d), 32'(err[d]), 32'd0);
         chk($sformatf("d%0d_mr_busy", d), 32'(busy[d]), 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         rv_seen = 1'b0;
         repeat (6) begin
            @(negedge clk);
            if (rvalid[d]) rv_seen = 1'b1;
         end
         chk($sformatf("d%0d_mr_norv", d), 32'(rv_seen), 32'd0);
         xact(d, 1'b0, LIS_LW, 10'h010, 32'h0, "mr_lw", rd);
         chk($sformatf("d%0d_mr_lw_c", d), rd, 32'h1234BEEF);
      end

      // Random mix of ops, alignments and direction mismatches
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 80; n++) begin
            logic [2:0] o;
            bit w;
            int a;
            o = 3'($urandom_range(0, 7));
            w = op_store(o);
            if ($urandom_range(0, 99) < 15) w = ~w;
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 99) < 70) a = a - (a % op_size(o));
            xact(d, w, o, 10'(a), $urandom, "rnd", rd);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
